mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates one shared single-port memory between an instruction-fetch port and a data port.
// Data accesses win ties, limited to MAX_D_STREAK in a row while a fetch waits. An access that
// receives no mem_ack_i within TIMEOUT busy cycles is aborted: the requester gets a ready pulse,
// a read returns 32'hDEADBEEF, and the sticky err_o flag is set.
//
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   if_req_i/if_addr_i             fetch request (held until if_ready_o) and address
//   if_rdata_o/if_ready_o          registered fetch read data, one-cycle completion pulse
//   d_req_i/d_we_i/d_addr_i/d_wdata_i  data request (held until d_ready_o), write flag, addr, data
//   d_rdata_o/d_ready_o            registered data read data, one-cycle completion pulse
//   mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o  memory request level and latched command
//   mem_rdata_i/mem_ack_i          memory read data and completion
//   err_o/err_clr_i                sticky timeout flag and its synchronous clear
module mem_arbiter #(
  parameter int unsigned MAX_D_STREAK = 2,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        if_ready_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  output logic [31:0] d_rdata_o,
  output logic        d_ready_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i,
  output logic        err_o,
  input  logic        err_clr_i
);

  localparam int unsigned CntW    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned StreakW = (MAX_D_STREAK < 1) ? 1 : $clog2(MAX_D_STREAK + 1);
  // Abort happens on the busy edge that would bring the count to TIMEOUT.
  localparam logic [CntW-1:0]    CntLast   = CntW'(TIMEOUT - 1);
  localparam logic [StreakW-1:0] StreakMax = StreakW'(MAX_D_STREAK);

  typedef enum logic [1:0] {StIdle, StBusyI, StBusyD} state_e;

  state_e              state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [31:0]         mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic                if_ready_q, if_ready_d;
  logic                d_ready_q, d_ready_d;
  logic [31:0]         if_rdata_q, if_rdata_d;
  logic [31:0]         d_rdata_q, d_rdata_d;
  logic                err_q, err_d;
  logic [StreakW-1:0]  streak_q, streak_d;
  logic [CntW-1:0]     cnt_q, cnt_d;

  logic                grant_ok;
  logic                pick_d;
  logic                done;
  logic [31:0]         rdata_nxt;

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ready_d  = 1'b0;
    d_ready_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    err_d       = err_q;
    streak_d    = streak_q;
    cnt_d       = cnt_q;
    done        = 1'b0;
    rdata_nxt   = '0;
    // No grant while any ready pulse is out: the completing requester may still be holding its
    // request, and holding off both ports keeps the streak rotation D,D,I under back-to-back load.
    grant_ok    = !if_ready_q && !d_ready_q;
    pick_d      = d_req_i && (!if_req_i || (streak_q < StreakMax));

    if (err_clr_i) begin
      err_d = 1'b0;
    end

    case (state_q)
      StIdle: begin
        if (grant_ok && pick_d) begin
          state_d     = StBusyD;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we_i;
          mem_addr_d  = d_addr_i;
          mem_wdata_d = d_wdata_i;
          cnt_d       = '0;
          if (!if_req_i) begin
            streak_d = '0;
          end else if (streak_q != StreakMax) begin
            streak_d = streak_q + StreakW'(1);
          end
        end else if (grant_ok && if_req_i) begin
          state_d    = StBusyI;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = if_addr_i;
          cnt_d      = '0;
          streak_d   = '0;
        end
      end
      StBusyI, StBusyD: begin
        if (mem_ack_i) begin
          done      = 1'b1;
          rdata_nxt = mem_rdata_i;
        end else if (cnt_q == CntLast) begin
          // Timeout abort; setting err here overrides a concurrent err_clr_i.
          done      = 1'b1;
          rdata_nxt = 32'hDEADBEEF;
          err_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
        if (done) begin
          state_d   = StIdle;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (state_q == StBusyI) begin
            if_ready_d = 1'b1;
            if_rdata_d = rdata_nxt;
          end else begin
            d_ready_d = 1'b1;
            if (!mem_we_q) begin
              d_rdata_d = rdata_nxt;
            end
          end
        end
      end
      default: begin
        state_d   = StIdle;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ready_q  <= 1'b0;
      d_ready_q   <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      err_q       <= 1'b0;
      streak_q    <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ready_q  <= if_ready_d;
      d_ready_q   <= d_ready_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      err_q       <= err_d;
      streak_q    <= streak_d;
      cnt_q       <= cnt_d;
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign if_ready_o  = if_ready_q;
  assign d_ready_o   = d_ready_q;
  assign if_rdata_o  = if_rdata_q;
  assign d_rdata_o   = d_rdata_q;
  assign err_o       = err_q;

endmodule
